// File: rtl/apb_reg_bridge_pkg.sv
// Shared types and helpers for the APB-to-register-bank bridge.
package apb_reg_bridge_pkg;

  // Transfer sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 32'd16;

  // Width of a counter that must hold the value timeout_cycles (never below one bit).
  function automatic int unsigned to_cnt_width(input int unsigned timeout_cycles);
    int unsigned w;
    w = $clog2(timeout_cycles + 32'd1);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

  localparam int unsigned TO_CNT_WIDTH = to_cnt_width(TIMEOUT_CYCLES_DEFAULT);

  // Address outside the decoded window, or not aligned to the full bus width.
  // The address is zero-extended to 32 bits by the caller.
  function automatic logic is_decode_err(input logic [31:0]  addr,
                                         input int unsigned reg_space_bytes,
                                         input int unsigned strb_width);
    logic [31:0] align_mask;
    align_mask = strb_width - 32'd1;
    return (addr >= reg_space_bytes) || ((addr & align_mask) != 32'd0);
  endfunction

endpackage

// File: rtl/apb_reg_bridge_if.sv
// APB4 completer-side signal bundle; master drives requests, slave answers.
interface apb_reg_bridge_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                      PSELx;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_WIDTH-1:0]     PADDR;
  logic [DATA_WIDTH-1:0]     PWDATA;
  logic [DATA_WIDTH/8-1:0]   PSTRB;
  logic [DATA_WIDTH-1:0]     PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_reg_bridge_timeout_ctr.sv
// Wait-cycle counter: expired is high during the TIMEOUT_CYCLES-th enabled cycle
// after a clear. A TIMEOUT_CYCLES of zero removes the counter entirely.
module apb_timeout_ctr
  import apb_reg_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CNT_W = to_cnt_width(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 32'sd0) begin : g_off
      logic unused_s;
      assign unused_s = ^{clk, rst, clear, enable};
      assign expired  = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 32'sd1);
      logic [CNT_W-1:0] cnt_r;
      logic             at_last_s;

      assign at_last_s = (cnt_r == LAST);
      assign expired   = enable && at_last_s;

      // Count enabled cycles from the last clear, saturating at the expiry value.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
          cnt_r <= {CNT_W{1'b0}};
        end else if (enable && !at_last_s) begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_r <= cnt_r;
        end
      end
    end
  endgenerate
endmodule

// File: rtl/apb_reg_bridge.sv
// APB4 completer that turns each APB access into one register-bank request,
// holds wait states until the bank answers (or times out) and flags decode,
// alignment and timeout errors. Every APB and register-side output is a flop.
module apb_reg_bridge
  import apb_reg_bridge_pkg::*;
#(
  parameter int  ADDR_WIDTH      = 12,
  parameter int  DATA_WIDTH      = 32,
  parameter int  REG_SPACE_BYTES = 64,
  parameter int  TIMEOUT_CYCLES  = 16,
  localparam int STRB_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  apb_reg_bridge_if.slave       apb,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [STRB_WIDTH-1:0] reg_strb,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ready,
  input  logic                  reg_error
);
  state_e                  state_r;
  logic                    write_r;
  logic                    dec_err_r;
  logic                    pready_r;
  logic                    pslverr_r;
  logic [DATA_WIDTH-1:0]   prdata_r;
  logic                    reg_wr_en_r;
  logic                    reg_rd_en_r;
  logic [ADDR_WIDTH-1:0]   reg_addr_r;
  logic [DATA_WIDTH-1:0]   reg_wdata_r;
  logic [STRB_WIDTH-1:0]   reg_strb_r;

  logic                    setup_s;
  logic                    dec_err_s;
  logic [DATA_WIDTH-1:0]   rsp_data_s;
  logic                    cnt_clear_s;
  logic                    cnt_enable_s;
  logic                    expired_s;

  assign apb.PREADY  = pready_r;
  assign apb.PSLVERR = pslverr_r;
  assign apb.PRDATA  = prdata_r;
  assign reg_wr_en   = reg_wr_en_r;
  assign reg_rd_en   = reg_rd_en_r;
  assign reg_addr    = reg_addr_r;
  assign reg_wdata   = reg_wdata_r;
  assign reg_strb    = reg_strb_r;

  // The timeout window opens at the request cycle and keeps running while draining.
  assign cnt_clear_s  = (state_r == IDLE);
  assign cnt_enable_s = (state_r == REQ) || (state_r == WAIT) || (state_r == DRAIN);

  apb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (cnt_clear_s),
    .enable  (cnt_enable_s),
    .expired (expired_s)
  );

  // Recognise a setup phase, decode its address and pick the data a bank answer returns.
  always_comb begin
    setup_s   = apb.PSELx && !apb.PENABLE;
    dec_err_s = is_decode_err(32'(apb.PADDR), REG_SPACE_BYTES, STRB_WIDTH);
    if (write_r) begin
      rsp_data_s = {DATA_WIDTH{1'b0}};
    end else begin
      rsp_data_s = reg_rdata;
    end
  end

  // Transfer sequencer: latches the access, issues one request, waits, then responds.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r     <= IDLE;
      write_r     <= 1'b0;
      dec_err_r   <= 1'b0;
      pready_r    <= 1'b0;
      pslverr_r   <= 1'b0;
      prdata_r    <= {DATA_WIDTH{1'b0}};
      reg_wr_en_r <= 1'b0;
      reg_rd_en_r <= 1'b0;
      reg_addr_r  <= {ADDR_WIDTH{1'b0}};
      reg_wdata_r <= {DATA_WIDTH{1'b0}};
      reg_strb_r  <= {STRB_WIDTH{1'b0}};
    end else begin
      reg_wr_en_r <= 1'b0;
      reg_rd_en_r <= 1'b0;
      pready_r    <= 1'b0;
      pslverr_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (setup_s) begin
            write_r     <= apb.PWRITE;
            dec_err_r   <= dec_err_s;
            reg_addr_r  <= apb.PADDR;
            reg_wdata_r <= apb.PWDATA;
            reg_strb_r  <= apb.PWRITE ? apb.PSTRB : {STRB_WIDTH{1'b0}};
            reg_wr_en_r <= apb.PWRITE && !dec_err_s;
            reg_rd_en_r <= !apb.PWRITE && !dec_err_s;
            state_r     <= REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (!apb.PSELx) begin
            // Abandoned access: drain only if a bank answer is still owed.
            state_r <= (dec_err_r || reg_ready || expired_s) ? IDLE : DRAIN;
          end else if (dec_err_r) begin
            pready_r  <= 1'b1;
            pslverr_r <= 1'b1;
            prdata_r  <= {DATA_WIDTH{1'b0}};
            state_r   <= RESP;
          end else if (reg_ready) begin
            pready_r  <= 1'b1;
            pslverr_r <= reg_error;
            prdata_r  <= rsp_data_s;
            state_r   <= RESP;
          end else if (expired_s) begin
            pready_r  <= 1'b1;
            pslverr_r <= 1'b1;
            prdata_r  <= {DATA_WIDTH{1'b0}};
            state_r   <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (!apb.PSELx) begin
            state_r <= (reg_ready || expired_s) ? IDLE : DRAIN;
          end else if (reg_ready) begin
            pready_r  <= 1'b1;
            pslverr_r <= reg_error;
            prdata_r  <= rsp_data_s;
            state_r   <= RESP;
          end else if (expired_s) begin
            pready_r  <= 1'b1;
            pslverr_r <= 1'b1;
            prdata_r  <= {DATA_WIDTH{1'b0}};
            state_r   <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        DRAIN: begin
          if (reg_ready || expired_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_reg_bridge.sv
// Scoreboard bench for apb_reg_bridge: stimulus queues expected register
// requests and APB responses; negedge monitors pop and compare them.
module tb_apb_reg_bridge;
  logic        clk = 1'b0;
  logic        PRESET;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_strb;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic        reg_error;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          cyc;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  apb_reg_bridge_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  apb_reg_bridge #(
    .ADDR_WIDTH      (12),
    .DATA_WIDTH      (32),
    .REG_SPACE_BYTES (64),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .PCLK      (clk),
    .PRESET    (PRESET),
    .apb       (bus),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_strb  (reg_strb),
    .reg_rdata (reg_rdata),
    .reg_ready (reg_ready),
    .reg_error (reg_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pready"},  32'(bus.PREADY),  32'h0);
    chk({tag, "_pslverr"}, 32'(bus.PSLVERR), 32'h0);
    chk({tag, "_prdata"},  bus.PRDATA,       32'h0);
    chk({tag, "_wr_en"},   32'(reg_wr_en),   32'h0);
    chk({tag, "_rd_en"},   32'(reg_rd_en),   32'h0);
    chk({tag, "_addr"},    32'(reg_addr),    32'h0);
    chk({tag, "_wdata"},   reg_wdata,        32'h0);
    chk({tag, "_strb"},    32'(reg_strb),    32'h0);
  endtask

  // Register-request monitor.
  always @(negedge clk) begin : mon_req
    req_t r;
    if (!PRESET && (reg_wr_en || reg_rd_en)) begin
      if (req_q.size() == 0) begin
        chk("unexpected_req", 32'({reg_wr_en, reg_rd_en}), 32'h0);
      end else begin
        r = req_q.pop_front();
        chk("req_wr_en", 32'(reg_wr_en), 32'(r.wr));
        chk("req_rd_en", 32'(reg_rd_en), 32'(!r.wr));
        chk("req_addr",  32'(reg_addr),  32'(r.addr));
        chk("req_strb",  32'(reg_strb),  32'(r.strb));
        if (r.wr) chk("req_wdata", reg_wdata, r.wdata);
        chk("req_cycle", 32'(cyc), 32'(r.cyc));
      end
    end
  end

  // APB response monitor.
  always @(negedge clk) begin : mon_rsp
    rsp_t r;
    if (!PRESET && bus.PREADY) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_pready", 32'(bus.PREADY), 32'h0);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_pslverr", 32'(bus.PSLVERR), 32'(r.err));
        chk("rsp_prdata",  bus.PRDATA,       r.data);
        chk("rsp_cycle",   32'(cyc),         32'(r.cyc));
      end
    end
  end

  // One APB access, entered just after a rising edge (that cycle is T0).
  // rdy_dly: cycles after REQ at which reg_ready pulses, -1 for never.
  // exp_lat: PREADY cycle relative to T1.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int rdy_dly, input logic [31:0] rdata,
                          input logic rerr, input logic exp_req, input logic exp_err,
                          input logic [31:0] exp_data, input int exp_lat);
    int t1;
    bit done;
    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    bus.PSTRB   = strb;
    t1 = cyc + 1;
    if (exp_req) req_q.push_back('{wr, addr, wdata, wr ? strb : 4'h0, t1});
    rsp_q.push_back('{exp_err, exp_data, t1 + exp_lat});
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      reg_ready = (n == rdy_dly);
      reg_rdata = rdata;
      reg_error = rerr;
      @(negedge clk);
      done = bus.PREADY;
      @(posedge clk); #1;
    end
    reg_ready   = 1'b0;
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL xfer_no_pready: addr %h got no PREADY within 40 cycles", addr);
    end
  endtask

  initial begin
    PRESET      = 1'b1;
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 12'h0;
    bus.PWDATA  = 32'h0;
    bus.PSTRB   = 4'h0;
    reg_rdata   = 32'h0;
    reg_ready   = 1'b0;
    reg_error   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    PRESET = 1'b0;
    @(posedge clk); #1;

    // Write, bank ready in the REQ cycle: PREADY at T2, PRDATA 0.
    apb_xfer(1'b1, 12'h008, 32'hA5A5_0001, 4'hF, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    // Back-to-back read returning a bank error one cycle after REQ.
    apb_xfer(1'b0, 12'h00C, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D, 2);
    // Read, bank ready 3 cycles after REQ.
    apb_xfer(1'b0, 12'h010, 32'h0, 4'hF, 3, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 4);
    // Out-of-range read and misaligned write: no request, error at T2.
    apb_xfer(1'b0, 12'h040, 32'h0, 4'hF, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0, 1);
    apb_xfer(1'b1, 12'h006, 32'h1111_2222, 4'hF, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0, 1);
    // Last word in range, partial strobes.
    apb_xfer(1'b1, 12'h03C, 32'h0BAD_BEEF, 4'h3, 2, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0, 3);
    // Bank never answers: timeout error at T1+16.
    apb_xfer(1'b0, 12'h020, 32'h0, 4'hF, -1, 32'h5555_AAAA, 1'b0, 1'b1, 1'b1, 32'h0, 16);
    // Late answer after the timeout must not produce another PREADY.
    reg_ready = 1'b1;
    reg_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    reg_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Answer in the same cycle the timeout would fire: the answer wins.
    apb_xfer(1'b0, 12'h024, 32'h0, 4'hF, 15, 32'h7777_0000, 1'b0, 1'b1, 1'b0, 32'h7777_0000, 16);

    // Selection dropped during WAIT, bank answers two cycles later: no PREADY.
    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 12'h014;
    req_q.push_back('{1'b0, 12'h014, 32'h0, 4'h0, cyc + 1});
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reg_ready = 1'b1;
    reg_rdata = 32'hBAD0_0001;
    @(posedge clk); #1;
    reg_ready = 1'b0;
    apb_xfer(1'b1, 12'h018, 32'h0000_BEEF, 4'hC, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0, 1);

    // Leave non-zero PRDATA behind, then reset in the middle of a WAIT.
    apb_xfer(1'b0, 12'h030, 32'h0, 4'hF, 0, 32'h0F0F_0F0F, 1'b0, 1'b1, 1'b0, 32'h0F0F_0F0F, 1);
    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 12'h01C;
    bus.PWDATA  = 32'hDEAD_BEEF;
    req_q.push_back('{1'b0, 12'h01C, 32'hDEAD_BEEF, 4'h0, cyc + 1});
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    @(posedge clk); #1;
    PRESET = 1'b1;
    @(posedge clk); #1;
    PRESET      = 1'b0;
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    reg_ready   = 1'b1;
    reg_rdata   = 32'h9999_9999;
    @(negedge clk);
    chk_all_zero("reset_mid");
    @(posedge clk); #1;
    reg_ready = 1'b0;
    apb_xfer(1'b1, 12'h004, 32'h0102_0304, 4'hF, 1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0, 2);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("req_queue_drained", 32'(req_q.size()), 32'h0);
    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
